tx_serializer_10b: RTL and testbench

Downstream stage of the 8b/10b symbol encoders. Accepts 10-bit encoded symbols through a one-deep valid/ready holding register and shifts them out MSB-first (bit 9 = 'a' first), one bit per clk. Tracks line running disparity. When no symbol is waiting, it inserts K28.5 comma idles of the correct polarity so the line never stalls.

---
 rtl/tx_serializer_10b.sv | 212 +++++++++++++++++++++
 tb/tb_tx_serializer_10b.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tx_serializer_10b.sv
// ---------------------------------------------------------------------------
// tx_serializer_10b
//
// Serializer behind the 8b/10b symbol encoders. Encoded 10-bit symbols enter
// through a one-deep valid/ready holding register and are shifted out MSB
// first (bit 9, the 'a' bit, leads), one bit per clock, with no gap between
// consecutive symbols. The line running disparity is tracked on every loaded
// symbol. When nothing is waiting at a symbol boundary the block either
// inserts a K28.5 comma of the polarity that matches the current running
// disparity (IDLE_FILL=1) or lets the line go idle (IDLE_FILL=0).
//
// Parameters
//   IDLE_FILL     1: fill empty symbol slots with K28.5, 0: drop ser_en
//   K28_5_NEG     comma used at RD-; the RD+ comma is its bitwise inverse
//
// Ports
//   clk           bit clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   sym_in        encoded symbol, bit 9 transmitted first
//   sym_valid     sym_in is valid
//   sym_ready     holding register empty (combinational, = !hold_full)
//   ser_out       registered serial line bit
//   ser_en        ser_out carries a valid bit
//   sym_start     ser_out currently carries bit 9 of a symbol
//   idle_ins      sym_start cycle of an inserted comma
//   rd_cur        running disparity after the last loaded symbol (1 = RD+)
//   disp_err      sticky flag: a loaded symbol had an illegal ones-count
//   disp_err_clr  synchronous clear of disp_err (a new error wins)
// ---------------------------------------------------------------------------
module tx_serializer_10b #(
  parameter bit         IDLE_FILL = 1'b1,
  parameter logic [9:0] K28_5_NEG = 10'b0011111010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       ser_out,
  output logic       ser_en,
  output logic       sym_start,
  output logic       idle_ins,
  output logic       rd_cur,
  output logic       disp_err,
  input  logic       disp_err_clr
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Number of ones in a 10-bit symbol.
  function automatic logic [3:0] ones10(input logic [9:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 10; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  state_e     state_q,     state_d;
  logic [9:0] hold_q,      hold_d;
  logic       hold_full_q, hold_full_d;
  logic [9:0] shreg_q,     shreg_d;
  logic [3:0] bit_cnt_q,   bit_cnt_d;
  logic       ser_out_q,   ser_out_d;
  logic       ser_en_q,    ser_en_d;
  logic       sym_start_q, sym_start_d;
  logic       idle_ins_q,  idle_ins_d;
  logic       rd_q,        rd_d;
  logic       disp_err_q,  disp_err_d;

  logic       load_edge_s;
  logic       load_sym_s;
  logic [9:0] next_sym_s;
  logic [9:0] comma_s;
  logic [3:0] ones_s;
  logic [3:0] bit_idx_s;

  // Comma polarity follows the disparity before this load is accounted for.
  assign comma_s   = rd_q ? ~K28_5_NEG : K28_5_NEG;
  // Bit to place on the line after the current edge; only used while
  // bit_cnt is 0..8, so the subtraction never wraps when it matters.
  assign bit_idx_s = 4'd8 - bit_cnt_q;
  assign ones_s    = ones10(next_sym_s);

  // Symbol-boundary detection: IDLE leaves as soon as there is something to
  // send (a held symbol, or always when filling with commas); SHIFT reloads
  // after the tenth bit.
  always_comb begin
    load_edge_s = 1'b0;
    case (state_q)
      ST_IDLE:  load_edge_s = hold_full_q || IDLE_FILL;
      ST_SHIFT: load_edge_s = (bit_cnt_q == 4'd9);
      default:  load_edge_s = 1'b0;
    endcase
  end

  // Next-state logic for holding register, shifter, line outputs and
  // disparity tracking.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    ser_out_d   = ser_out_q;
    ser_en_d    = ser_en_q;
    sym_start_d = 1'b0;
    idle_ins_d  = 1'b0;
    rd_d        = rd_q;
    disp_err_d  = disp_err_clr ? 1'b0 : disp_err_q;
    load_sym_s  = 1'b0;
    next_sym_s  = 10'd0;

    // Capture into the holding register. Ready is low while full, so a
    // capture never coincides with the unload below.
    if (sym_valid && !hold_full_q) begin
      hold_d      = sym_in;
      hold_full_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end

    // Choose what goes out next at a symbol boundary.
    if (load_edge_s) begin
      if (hold_full_q) begin
        next_sym_s  = hold_q;
        hold_full_d = 1'b0;
        load_sym_s  = 1'b1;
      end else if (IDLE_FILL) begin
        next_sym_s  = comma_s;
        idle_ins_d  = 1'b1;
        load_sym_s  = 1'b1;
      end else begin
        state_d     = ST_IDLE;
        ser_en_d    = 1'b0;
        ser_out_d   = 1'b0;
      end
    end else begin
      next_sym_s = 10'd0;
    end

    if (load_sym_s) begin
      // Bit 9 goes on the line at the load edge itself.
      ser_out_d   = next_sym_s[9];
      shreg_d     = next_sym_s;
      sym_start_d = 1'b1;
      ser_en_d    = 1'b1;
      bit_cnt_d   = 4'd0;
      state_d     = ST_SHIFT;
      case (ones_s)
        4'd6:    rd_d = 1'b1;
        4'd4:    rd_d = 1'b0;
        4'd5:    rd_d = rd_q;
        default: begin
          rd_d       = rd_q;
          disp_err_d = 1'b1;
        end
      endcase
    end else if (!load_edge_s && (state_q == ST_SHIFT)) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
      ser_out_d = shreg_q[bit_idx_s];
    end else if (!load_edge_s) begin
      // Parked in IDLE with nothing to send.
      ser_en_d  = 1'b0;
      ser_out_d = 1'b0;
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= 10'd0;
      hold_full_q <= 1'b0;
      shreg_q     <= 10'd0;
      bit_cnt_q   <= 4'd0;
      ser_out_q   <= 1'b0;
      ser_en_q    <= 1'b0;
      sym_start_q <= 1'b0;
      idle_ins_q  <= 1'b0;
      rd_q        <= 1'b0;
      disp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_out_q   <= ser_out_d;
      ser_en_q    <= ser_en_d;
      sym_start_q <= sym_start_d;
      idle_ins_q  <= idle_ins_d;
      rd_q        <= rd_d;
      disp_err_q  <= disp_err_d;
    end
  end

  assign sym_ready = !hold_full_q;
  assign ser_out   = ser_out_q;
  assign ser_en    = ser_en_q;
  assign sym_start = sym_start_q;
  assign idle_ins  = idle_ins_q;
  assign rd_cur    = rd_q;
  assign disp_err  = disp_err_q;

endmodule

// File: tb/tb_tx_serializer_10b.sv
// Directed bench for tx_serializer_10b. Instance A uses comma fill, instance
// B has IDLE_FILL=0. Outputs are sampled 1 time unit after the rising edge.
module tb_tx_serializer_10b;

  localparam logic [9:0] KN  = 10'b0011111010; // K28.5 at RD- (6 ones)
  localparam logic [9:0] KP  = 10'b1100000101; // K28.5 at RD+ (4 ones)
  localparam logic [9:0] D5  = 10'b0011110100; // 5 ones
  localparam logic [9:0] S1  = 10'b0011110011; // 6 ones
  localparam logic [9:0] S2  = 10'b1100001100; // 4 ones
  localparam logic [9:0] S3  = 10'b0011111010; // 6 ones
  localparam logic [9:0] BAD = 10'b1111111000; // 7 ones

  logic       clk;
  logic       rst_n;
  logic [9:0] sd_a, sd_b;
  logic       sv_a, sv_b;
  logic       clr_a, clr_b;
  logic       rdy_a, so_a, se_a, ss_a, ii_a, rc_a, de_a;
  logic       rdy_b, so_b, se_b, ss_b, ii_b, rc_b, de_b;

  int n_cmp = 0;
  int n_err = 0;

  // Output view of whichever instance a step is looking at.
  logic cur;
  logic m_so, m_se, m_ss, m_ii, m_rc, m_rdy;
  always_comb begin
    m_so  = cur ? so_b  : so_a;
    m_se  = cur ? se_b  : se_a;
    m_ss  = cur ? ss_b  : ss_a;
    m_ii  = cur ? ii_b  : ii_a;
    m_rc  = cur ? rc_b  : rc_a;
    m_rdy = cur ? rdy_b : rdy_a;
  end

  tx_serializer_10b #(.IDLE_FILL(1'b1), .K28_5_NEG(KN)) dut_a (
    .clk(clk), .rst_n(rst_n), .sym_in(sd_a), .sym_valid(sv_a), .sym_ready(rdy_a),
    .ser_out(so_a), .ser_en(se_a), .sym_start(ss_a), .idle_ins(ii_a),
    .rd_cur(rc_a), .disp_err(de_a), .disp_err_clr(clr_a)
  );

  tx_serializer_10b #(.IDLE_FILL(1'b0), .K28_5_NEG(KN)) dut_b (
    .clk(clk), .rst_n(rst_n), .sym_in(sd_b), .sym_valid(sv_b), .sym_ready(rdy_b),
    .ser_out(so_b), .ser_en(se_b), .sym_start(ss_b), .idle_ins(ii_b),
    .rd_cur(rc_b), .disp_err(de_b), .disp_err_clr(clr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called just after a load edge. Checks the start-of-symbol flags, then
  // collects the 10 line bits. After the first bit edge it checks sym_ready
  // and updates that instance's valid/data to (nv, nd).
  task automatic shift_sym(input logic sel, input string tag, input logic [9:0] exp,
                           input logic exp_idle, input logic exp_rd, input logic exp_rdy,
                           input logic nv, input logic [9:0] nd);
    logic [9:0] b;
    cur = sel;
    #0;
    chk({tag, ".sym_start"}, {9'd0, m_ss}, 10'd1);
    chk({tag, ".idle_ins"},  {9'd0, m_ii}, {9'd0, exp_idle});
    chk({tag, ".ser_en"},    {9'd0, m_se}, 10'd1);
    chk({tag, ".rd_cur"},    {9'd0, m_rc}, {9'd0, exp_rd});
    b[9] = m_so;
    tick();
    if (sel) begin sv_b = nv; sd_b = nd; end
    else     begin sv_a = nv; sd_a = nd; end
    chk({tag, ".sym_ready"}, {9'd0, m_rdy}, {9'd0, exp_rdy});
    chk({tag, ".start_low"}, {9'd0, m_ss}, 10'd0);
    b[8] = m_so;
    for (int i = 7; i >= 0; i--) begin
      tick();
      b[i] = m_so;
    end
    chk({tag, ".bits"}, b, exp);
  endtask

  initial begin
    cur   = 1'b0;
    rst_n = 1'b0;
    sd_a  = 10'd0; sv_a = 1'b0; clr_a = 1'b0;
    sd_b  = 10'd0; sv_b = 1'b0; clr_b = 1'b0;
    #1;
    chk("rst.ser_out",   {9'd0, so_a},  10'd0);
    chk("rst.ser_en",    {9'd0, se_a},  10'd0);
    chk("rst.sym_start", {9'd0, ss_a},  10'd0);
    chk("rst.idle_ins",  {9'd0, ii_a},  10'd0);
    chk("rst.rd_cur",    {9'd0, rc_a},  10'd0);
    chk("rst.disp_err",  {9'd0, de_a},  10'd0);
    chk("rst.sym_ready", {9'd0, rdy_a}, 10'd1);
    tick();
    tick();
    rst_n = 1'b1;

    // Comma stream right after reset release, alternating polarity.
    tick();
    shift_sym(1'b0, "c0", KN, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0);
    tick();
    shift_sym(1'b0, "c1", KP, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0);
    tick();
    shift_sym(1'b0, "c2", KN, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0);

    // Single 5-ones symbol offered during a comma.
    tick();
    sv_a = 1'b1; sd_a = D5;
    shift_sym(1'b0, "c3", KP, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    tick();
    chk("d5.ready_back", {9'd0, rdy_a}, 10'd1);
    shift_sym(1'b0, "d5", D5, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);

    // Continuous valid: three back-to-back data symbols.
    tick();
    sv_a = 1'b1; sd_a = S1;
    shift_sym(1'b0, "c4", KN, 1'b1, 1'b1, 1'b0, 1'b1, S2);
    tick();
    shift_sym(1'b0, "s1", S1, 1'b0, 1'b1, 1'b0, 1'b1, S3);
    tick();
    shift_sym(1'b0, "s2", S2, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    tick();
    shift_sym(1'b0, "s3", S3, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0);

    // Illegal ones-count: sticky error, disparity held, then cleared.
    tick();
    sv_a = 1'b1; sd_a = BAD;
    shift_sym(1'b0, "c5", KP, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    chk("bad.err_before", {9'd0, de_a}, 10'd0);
    tick();
    chk("bad.disp_err", {9'd0, de_a}, 10'd1);
    shift_sym(1'b0, "bad", BAD, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
    chk("bad.sticky", {9'd0, de_a}, 10'd1);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    chk("bad.cleared", {9'd0, de_a}, 10'd0);
    shift_sym(1'b0, "c6", KN, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0);

    // Reset asserted four bits into a symbol.
    tick();
    chk("c7.sym_start", {9'd0, ss_a}, 10'd1);
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst.ser_en",    {9'd0, se_a},  10'd0);
    chk("mrst.ser_out",   {9'd0, so_a},  10'd0);
    chk("mrst.sym_start", {9'd0, ss_a},  10'd0);
    chk("mrst.rd_cur",    {9'd0, rc_a},  10'd0);
    chk("mrst.sym_ready", {9'd0, rdy_a}, 10'd1);
    tick();
    chk("mrst.held", {9'd0, se_a}, 10'd0);
    rst_n = 1'b1;
    tick();
    shift_sym(1'b0, "r0", KN, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0);
    tick();
    shift_sym(1'b0, "r1", KP, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0);

    // Instance B: no fill, line idles between symbols.
    cur = 1'b1;
    chk("b.idle_en", {9'd0, se_b}, 10'd0);
    sv_b = 1'b1; sd_b = D5;
    tick();
    sv_b = 1'b0;
    chk("b.accept_en",  {9'd0, se_b},  10'd0);
    chk("b.accept_rdy", {9'd0, rdy_b}, 10'd0);
    tick();
    shift_sym(1'b1, "b1", D5, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
    tick();
    chk("b.en_off",    {9'd0, se_b}, 10'd0);
    chk("b.start_off", {9'd0, ss_b}, 10'd0);
    chk("b.out_off",   {9'd0, so_b}, 10'd0);
    tick();
    tick();
    chk("b.still_off", {9'd0, se_b}, 10'd0);
    sv_b = 1'b1; sd_b = S1;
    tick();
    sv_b = 1'b0;
    chk("b.wait_en", {9'd0, se_b}, 10'd0);
    tick();
    shift_sym(1'b1, "b2", S1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0);
    tick();
    chk("b.en_off2", {9'd0, se_b}, 10'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
